// File: rtl/mavlink_pkg.sv
// mavlink_pkg: shared MAVLink v1 constants, TX state encoding and X.25 CRC step
package mavlink_pkg;

    localparam logic [7:0] STX                 = 8'hFE;
    localparam logic [7:0] MSGID_HEARTBEAT     = 8'd0;
    localparam logic [7:0] HEARTBEAT_LEN       = 8'd9;
    localparam logic [7:0] HEARTBEAT_CRC_EXTRA = 8'd50;
    localparam logic [7:0] MAVLINK_VERSION     = 8'd3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CRCX,
        CRC,
        DONE
    } tx_state_t;

    // One MCRF4XX byte step; every intermediate is truncated to its declared width.
    function automatic logic [15:0] crc_x25_step(input logic [15:0] crc, input logic [7:0] b);
        logic [7:0] t;
        t = b ^ crc[7:0];
        t = t ^ {t[3:0], 4'h0};
        return {8'h00, crc[15:8]} ^ {t, 8'h00} ^ {5'h00, t, 3'h0} ^ {12'h000, t[7:4]};
    endfunction

endpackage

// File: rtl/mavlink_crc_x25.sv
// mavlink_crc_x25: 16-bit X.25 CRC accumulator, reusable by any MAVLink TX block
module mavlink_crc_x25
    import mavlink_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Clear to the seed at frame start; fold one byte whenever enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= 16'hFFFF;
        else if (clr)
            crc <= 16'hFFFF;
        else if (en)
            crc <= crc_x25_step(crc, data);
    end

endmodule

// File: rtl/mavlink_heartbeat_tx.sv
// mavlink_heartbeat_tx: serialises one MAVLink v1 HEARTBEAT frame onto a valid/ready byte stream
module mavlink_heartbeat_tx
    import mavlink_pkg::*;
#(
    parameter logic [7:0] SYS_ID     = 8'd1,
    parameter logic [7:0] COMP_ID    = 8'd1,
    parameter logic [7:0] MAV_TYPE   = 8'd2,
    parameter logic [7:0] AUTOPILOT  = 8'd0,
    parameter logic [7:0] BASE_MODE  = 8'd0,
    parameter logic [7:0] SYS_STATUS = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] custom_mode,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    tx_state_t   state, next;
    logic [4:0]  idx;
    logic [7:0]  seq;
    logic [31:0] cm;
    logic [15:0] crc;
    logic        hs, accept, crc_en;
    logic [7:0]  crc_data;

    assign tx_valid = (state == HDR) || (state == PAYLOAD) || (state == CRC);
    assign hs       = tx_valid && tx_ready;
    assign accept   = (state == IDLE) && start;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign crc_en   = (hs && idx != 5'd0 && idx <= 5'd14) || (state == CRCX);
    assign crc_data = (state == CRCX) ? HEARTBEAT_CRC_EXTRA : tx_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    // Next state: each section advances only when its last byte is handshaken.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? HDR : IDLE;
            HDR:     next = (hs && idx == 5'd5) ? PAYLOAD : HDR;
            PAYLOAD: next = (hs && idx == 5'd14) ? CRCX : PAYLOAD;
            CRCX:    next = CRC;
            CRC:     next = (hs && idx == 5'd16) ? DONE : CRC;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Byte index restarts on accept and advances only on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= 5'd0;
        else if (accept)
            idx <= 5'd0;
        else if (hs)
            idx <= idx + 5'd1;
    end

    // custom_mode is frozen at accept so mid-frame input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cm <= 32'd0;
        else if (accept)
            cm <= custom_mode;
    end

    // Sequence number persists across frames and bumps when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seq <= 8'd0;
        else if (next == DONE && state != DONE)
            seq <= seq + 8'd1;
    end

    // Frame byte for the current index; zero whenever nothing is offered.
    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            case (idx)
                5'd0:    tx_data = STX;
                5'd1:    tx_data = HEARTBEAT_LEN;
                5'd2:    tx_data = seq;
                5'd3:    tx_data = SYS_ID;
                5'd4:    tx_data = COMP_ID;
                5'd5:    tx_data = MSGID_HEARTBEAT;
                5'd6:    tx_data = cm[7:0];
                5'd7:    tx_data = cm[15:8];
                5'd8:    tx_data = cm[23:16];
                5'd9:    tx_data = cm[31:24];
                5'd10:   tx_data = MAV_TYPE;
                5'd11:   tx_data = AUTOPILOT;
                5'd12:   tx_data = BASE_MODE;
                5'd13:   tx_data = SYS_STATUS;
                5'd14:   tx_data = MAVLINK_VERSION;
                5'd15:   tx_data = crc[7:0];
                5'd16:   tx_data = crc[15:8];
                default: tx_data = 8'h00;
            endcase
        end
    end

    mavlink_crc_x25 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc)
    );

endmodule

// File: tb/tb_mavlink_heartbeat_tx.sv
// tb_mavlink_heartbeat_tx: randomized self-checking bench against a frame-level reference model
module tb_mavlink_heartbeat_tx;

    typedef logic [16:0][7:0] frame_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [31:0] custom_mode = 0;
    logic        busy, done, tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_seq = 0;

    mavlink_heartbeat_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .custom_mode (custom_mode),
        .busy        (busy),
        .done        (done),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    // pymavlink crc_accumulate written with plain integer arithmetic
    function automatic int crc_ref(input int c, input int b);
        int t;
        t = (b ^ c) & 255;
        t = (t ^ (t << 4)) & 255;
        return ((c >> 8) ^ (t << 8) ^ (t << 3) ^ (t >> 4)) & 16'hFFFF;
    endfunction

    function automatic frame_t model(input logic [7:0] s, input logic [31:0] m);
        frame_t f;
        int c;
        f[0] = 8'hFE; f[1] = 8'd9; f[2] = s; f[3] = 8'd1; f[4] = 8'd1; f[5] = 8'd0;
        for (int i = 0; i < 4; i++) f[6+i] = m[8*i +: 8];
        f[10] = 8'd2; f[11] = 8'd0; f[12] = 8'd0; f[13] = 8'd4; f[14] = 8'd3;
        c = 16'hFFFF;
        for (int i = 1; i <= 14; i++) c = crc_ref(c, int'(f[i]));
        c = crc_ref(c, 50);
        f[15] = c[7:0];
        f[16] = c[15:8];
        return f;
    endfunction

    // Called at the negedge where start=1 is presented in IDLE; k=0 is the first cycle after accept.
    task automatic collect(input int pct, input int stall_at, input int poke_at, input bit hold,
                           output frame_t got, output int n, output int done_k, output int done_cnt,
                           output int stall_bad, output int bubbles, output int busy_bad);
        bit pv, pr, poke_active, poked, stalled;
        logic [7:0] pd;
        int stall_left;
        got = '0; n = 0; done_k = -1; done_cnt = 0; stall_bad = 0; bubbles = 0; busy_bad = 0;
        pv = 0; pr = 0; pd = 0; poke_active = 0; poked = 0; stalled = 0; stall_left = 0;
        @(negedge clk);
        if (!hold) start = 0;
        for (int k = 0; k < 400; k++) begin
            if (poke_active) begin start = 0; poke_active = 0; end
            if (pv && !pr && (!tx_valid || tx_data !== pd)) stall_bad++;
            if (!busy) busy_bad++;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (n > 0 && n < 17 && !tx_valid) bubbles++;
            if (done_cnt > 0) break;
            if (poke_at >= 0 && n == poke_at && !poked) begin
                start = 1; custom_mode = $urandom; poked = 1; poke_active = 1;
            end
            if (stall_at >= 0 && n == stall_at && !stalled) begin stall_left = 4; stalled = 1; end
            if (stall_left > 0) begin tx_ready = 0; stall_left--; end
            else tx_ready = ($urandom_range(99) < pct);
            if (tx_valid && tx_ready && n < 17) begin got[n] = tx_data; n++; end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1;
        @(negedge clk);
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tx_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        exp_seq = 0;
    endtask

    task automatic test_basic();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz;
        logic [119:0] hdr;
        custom_mode = 32'h12345678;
        start = 1;
        exp = model(exp_seq, custom_mode);
        collect(100, -1, -1, 0, got, n, dk, dc, sb, bb, bz);
        hdr = got[14:0];
        checks++; if (hdr !== 120'h03_04_00_00_02_12_34_56_78_00_01_01_00_09_FE) begin
            errors++; $display("FAIL basic_bytes got %h want 030400000212345678000101 0009FE", hdr); end
        checks++; if (got !== exp) begin errors++; $display("FAIL basic_frame got %h want %h", got, exp); end
        // done is high in the cycle that ends at edge N+19
        checks++; if (dk != 18) begin errors++; $display("FAIL basic_done_cycle got %0d want 18", dk); end
        checks++; if (bb != 1) begin errors++; $display("FAIL basic_bubbles got %0d want 1", bb); end
        checks++; if (bz != 0) begin errors++; $display("FAIL basic_busy_low got %0d want 0", bz); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_once done %b busy %b want 0 0", done, busy); end
        exp_seq++;
    endtask

    task automatic test_backpressure();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz;
        custom_mode = 32'h12345678;
        start = 1;
        exp = model(exp_seq, custom_mode);
        collect(30, -1, -1, 0, got, n, dk, dc, sb, bb, bz);
        checks++; if (got !== exp) begin errors++; $display("FAIL bp_frame got %h want %h", got, exp); end
        checks++; if (sb != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", sb); end
        checks++; if (bb != 1) begin errors++; $display("FAIL bp_bubbles got %0d want 1", bb); end
        checks++; if (dc != 1) begin errors++; $display("FAIL bp_done got %0d want 1", dc); end
        exp_seq++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz, extra;
        custom_mode = $urandom;
        start = 1;
        exp = model(exp_seq, custom_mode);
        collect(100, -1, 7, 0, got, n, dk, dc, sb, bb, bz);
        checks++; if (got !== exp) begin errors++; $display("FAIL ign_frame got %h want %h", got, exp); end
        exp_seq++;
        extra = 0;
        repeat (30) begin @(negedge clk); if (tx_valid || busy) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_second got %0d active cycles want 0", extra); end
    endtask

    task automatic test_crcx_stall();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz;
        custom_mode = $urandom;
        start = 1;
        exp = model(exp_seq, custom_mode);
        collect(100, 15, -1, 0, got, n, dk, dc, sb, bb, bz);
        checks++; if (got !== exp) begin errors++; $display("FAIL crcx_frame got %h want %h", got, exp); end
        checks++; if (bb != 1) begin errors++; $display("FAIL crcx_bubbles got %0d want 1", bb); end
        checks++; if (sb != 0) begin errors++; $display("FAIL crcx_hold got %0d changes want 0", sb); end
        exp_seq++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz;
        start = 1;
        for (int f = 0; f < 257; f++) begin
            custom_mode = $urandom;
            exp = model(exp_seq, custom_mode);
            collect(100, -1, -1, 1, got, n, dk, dc, sb, bb, bz);
            checks++; if (got !== exp || dk != 18) begin
                errors++; $display("FAIL b2b_frame %0d got %h done@%0d want %h done@18", f, got, dk, exp); end
            exp_seq++;
            if (f == 256) start = 0;
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle %0d busy %b want 0", f, busy); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t got, exp;
        int n, dk, dc, sb, bb, bz, acc;
        custom_mode = $urandom;
        start = 1;
        tx_ready = 1;
        acc = 0;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 50 && acc < 10; k++) begin
            if (tx_valid && tx_ready) acc++;
            if (acc < 10) @(negedge clk);
        end
        @(negedge clk);
        tx_ready = 0;
        repeat (2) @(negedge clk);
        checks++; if (acc != 10 || !tx_valid) begin
            errors++; $display("FAIL rst_reach_byte10 got %0d valid %b want 10 1", acc, tx_valid); end
        rst_n = 0;
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async valid %b busy %b want 0 0", tx_valid, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        exp_seq = 0;
        @(negedge clk);
        custom_mode = $urandom;
        start = 1;
        exp = model(exp_seq, custom_mode);
        collect(50, -1, -1, 0, got, n, dk, dc, sb, bb, bz);
        checks++; if (got !== exp) begin errors++; $display("FAIL rst_next_frame got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_start();
        test_crcx_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
